// File: rtl/pfb_decim_sequencer.sv
// Aligns a channelised AXI-Stream to spectrum boundaries, keeps 1 of every cfg_decim spectra
// and regenerates TLAST. Define PFB_DECIM_WDOG_EN to build the backpressure stall watchdog.
module pfb_decim_sequencer #(
  parameter int DATA_W  = 32,
  parameter int NCHAN_W = 12,
  parameter int DECIM_W = 8,
  parameter int WDOG_W  = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NCHAN_W-1:0] cfg_nchan,
  input  logic [DECIM_W-1:0] cfg_decim,
  input  logic               cfg_load,
  input  logic [DATA_W-1:0]  s_tdata,
  input  logic               s_tvalid,
  input  logic               s_tlast,
  output logic               s_tready,
  output logic [DATA_W-1:0]  m_tdata,
  output logic               m_tvalid,
  output logic               m_tlast,
  input  logic               m_tready,
  output logic               frame_err,
  output logic [15:0]        spec_out,
  output logic               stall
);

  typedef enum logic [1:0] {IDLE, ALIGN, RUN} state_t;

  localparam logic [NCHAN_W-1:0] NCHAN_ONE = NCHAN_W'(1);
  localparam logic [DECIM_W-1:0] DECIM_ONE = DECIM_W'(1);

  state_t             state_q, state_d;
  logic [NCHAN_W-1:0] nchan_q, nchan_d;
  logic [DECIM_W-1:0] decim_q, decim_d;
  logic [NCHAN_W-1:0] ch_q, ch_d;
  logic [DECIM_W-1:0] sp_q, sp_d;
  logic [DATA_W-1:0]  m_tdata_q, m_tdata_d;
  logic               m_tvalid_q, m_tvalid_d;
  logic               m_tlast_q, m_tlast_d;
  logic               frame_err_q, frame_err_d;
  logic [15:0]        spec_out_q, spec_out_d;

  logic ready;
  logic accept;
  logic drain;
  logic ch_last;

  // Discarded spectra (sp != 0) never touch the output register, so they flow regardless of backpressure.
  always_comb begin
    ready = 1'b0;
    case (state_q)
      ALIGN:   ready = 1'b1;
      RUN:     ready = (sp_q != '0) || !m_tvalid_q || m_tready;
      default: ready = 1'b0;
    endcase
    if (cfg_load || reset) begin
      ready = 1'b0;
    end
  end

  assign s_tready = ready;
  assign accept   = ready & s_tvalid;
  assign drain    = m_tvalid_q & m_tready;
  assign ch_last  = (ch_q == nchan_q - NCHAN_ONE);

  always_comb begin
    state_d     = state_q;
    nchan_d     = nchan_q;
    decim_d     = decim_q;
    ch_d        = ch_q;
    sp_d        = sp_q;
    m_tdata_d   = m_tdata_q;
    m_tvalid_d  = m_tvalid_q;
    m_tlast_d   = m_tlast_q;
    frame_err_d = 1'b0;
    spec_out_d  = spec_out_q;

    if (drain) begin
      m_tvalid_d = 1'b0;
      if (m_tlast_q) begin
        spec_out_d = spec_out_q + 16'd1;
      end
    end

    if (cfg_load) begin
      nchan_d = (cfg_nchan == '0) ? NCHAN_ONE : cfg_nchan;
      decim_d = (cfg_decim == '0) ? DECIM_ONE : cfg_decim;
      ch_d    = '0;
      sp_d    = '0;
      state_d = ALIGN;
    end else begin
      case (state_q)
        ALIGN: begin
          if (accept && s_tlast) begin
            ch_d    = '0;
            sp_d    = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          if (accept) begin
            if (sp_q == '0) begin
              m_tdata_d  = s_tdata;
              m_tvalid_d = 1'b1;
              m_tlast_d  = ch_last;
            end
            // A TLAST on the errored beat already marks a boundary, so no realignment pass is needed.
            if (s_tlast != ch_last) begin
              frame_err_d = 1'b1;
              ch_d        = '0;
              sp_d        = '0;
              state_d     = s_tlast ? RUN : ALIGN;
            end else if (ch_last) begin
              ch_d = '0;
              sp_d = (sp_q == decim_q - DECIM_ONE) ? '0 : sp_q + DECIM_ONE;
            end else begin
              ch_d = ch_q + NCHAN_ONE;
            end
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

`ifdef PFB_DECIM_WDOG_EN
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              stall_q, stall_d;

  always_comb begin
    wdog_d = wdog_q;
    if (cfg_load || drain) begin
      wdog_d = '0;
    end else if (m_tvalid_q && !(&wdog_q)) begin
      wdog_d = wdog_q + WDOG_W'(1);
    end
    stall_d = &wdog_d;
  end

  assign stall = stall_q;
`else
  // Watchdog compiled out; WDOG_W stays in the parameter list so both builds share one interface.
  assign stall = 1'b0 & (WDOG_W > 0);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      nchan_q     <= NCHAN_ONE;
      decim_q     <= DECIM_ONE;
      ch_q        <= '0;
      sp_q        <= '0;
      m_tdata_q   <= '0;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
      frame_err_q <= 1'b0;
      spec_out_q  <= '0;
`ifdef PFB_DECIM_WDOG_EN
      wdog_q      <= '0;
      stall_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      nchan_q     <= nchan_d;
      decim_q     <= decim_d;
      ch_q        <= ch_d;
      sp_q        <= sp_d;
      m_tdata_q   <= m_tdata_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tlast_q   <= m_tlast_d;
      frame_err_q <= frame_err_d;
      spec_out_q  <= spec_out_d;
`ifdef PFB_DECIM_WDOG_EN
      wdog_q      <= wdog_d;
      stall_q     <= stall_d;
`endif
    end
  end

  assign m_tdata   = m_tdata_q;
  assign m_tvalid  = m_tvalid_q;
  assign m_tlast   = m_tlast_q;
  assign frame_err = frame_err_q;
  assign spec_out  = spec_out_q;

endmodule

// File: tb/tb_pfb_decim_sequencer.sv
// Directed bench for pfb_decim_sequencer: stream-position reference model checked every cycle,
// plus literal expectations per scenario. Watchdog expectations follow PFB_DECIM_WDOG_EN.
`timescale 1ns/1ps
module tb_pfb_decim_sequencer;

  localparam int DATA_W  = 32;
  localparam int NCHAN_W = 12;
  localparam int DECIM_W = 8;
  localparam int WDOG_W  = 4;
  localparam int WD_MAX  = (1 << WDOG_W) - 1;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic [NCHAN_W-1:0] cfg_nchan = '0;
  logic [DECIM_W-1:0] cfg_decim = '0;
  logic               cfg_load = 1'b0;
  logic [DATA_W-1:0]  s_tdata = '0;
  logic               s_tvalid = 1'b0;
  logic               s_tlast = 1'b0;
  logic               s_tready;
  logic [DATA_W-1:0]  m_tdata;
  logic               m_tvalid;
  logic               m_tlast;
  logic               m_tready = 1'b1;
  logic               frame_err;
  logic [15:0]        spec_out;
  logic               stall;

  always #5 clock = ~clock;

  pfb_decim_sequencer #(
    .DATA_W(DATA_W), .NCHAN_W(NCHAN_W), .DECIM_W(DECIM_W), .WDOG_W(WDOG_W)
  ) dut (
    .clock(clock), .reset(reset),
    .cfg_nchan(cfg_nchan), .cfg_decim(cfg_decim), .cfg_load(cfg_load),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .frame_err(frame_err), .spec_out(spec_out), .stall(stall)
  );

  int n_cmp = 0;
  int n_err = 0;
  int fe_seen = 0;
  bit rand_rdy = 1'b0;
  logic [DATA_W-1:0] got[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: position of each beat since alignment decides channel and spectrum phase.
  int          md_state = 0;  // 0 idle, 1 align, 2 run
  int          md_n = 1, md_d = 1, md_pos = 0, md_so = 0, md_wd = 0;
  bit          md_hv = 0, md_hl = 0, md_fe = 0, md_acc = 0, md_live = 0;
  logic [31:0] md_hd = '0;

  function automatic bit md_ready();
    if (reset || cfg_load) return 1'b0;
    case (md_state)
      1:       return 1'b1;
      2:       return (((md_pos / md_n) % md_d) != 0) || !md_hv || m_tready;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clock) begin : model_step
    bit acc, drain, lastc;
    int ch, sp;
    acc    = md_ready() && s_tvalid;
    drain  = md_hv && m_tready;
    md_acc = acc;
    if (reset) begin
      md_state = 0; md_n = 1; md_d = 1; md_pos = 0;
      md_hv = 0; md_hd = '0; md_hl = 0; md_so = 0; md_wd = 0; md_fe = 0;
      md_live = 1;
    end else begin
      if (cfg_load || drain) md_wd = 0;
      else if (md_hv && md_wd < WD_MAX) md_wd++;
      md_fe = 0;
      if (drain) begin
        md_hv = 0;
        if (md_hl) md_so = (md_so + 1) % 65536;
      end
      if (cfg_load) begin
        md_n = (cfg_nchan == 0) ? 1 : int'(cfg_nchan);
        md_d = (cfg_decim == 0) ? 1 : int'(cfg_decim);
        md_pos = 0;
        md_state = 1;
      end else if (acc && md_state == 1) begin
        if (s_tlast) begin
          md_state = 2;
          md_pos = 0;
        end
      end else if (acc && md_state == 2) begin
        ch = md_pos % md_n;
        sp = (md_pos / md_n) % md_d;
        lastc = (ch == md_n - 1);
        if (sp == 0) begin
          md_hv = 1; md_hd = s_tdata; md_hl = lastc;
        end
        if (s_tlast != lastc) begin
          md_fe = 1;
          md_pos = 0;
          md_state = s_tlast ? 2 : 1;
        end else begin
          md_pos = (md_pos + 1) % (md_n * md_d);
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clock) begin
    if (md_live) begin
      chk("s_tready", {31'b0, s_tready}, {31'b0, md_ready()});
      chk("m_tvalid", {31'b0, m_tvalid}, {31'b0, md_hv});
      if (md_hv) begin
        chk("m_tdata", m_tdata, md_hd);
        chk("m_tlast", {31'b0, m_tlast}, {31'b0, md_hl});
      end
      chk("frame_err", {31'b0, frame_err}, {31'b0, md_fe});
      chk("spec_out", {16'b0, spec_out}, md_so[31:0]);
`ifdef PFB_DECIM_WDOG_EN
      chk("stall", {31'b0, stall}, {31'b0, (md_wd == WD_MAX)});
`else
      chk("stall", {31'b0, stall}, 32'd0);
`endif
      if (frame_err) fe_seen++;
      if (m_tvalid && m_tready) begin
        got.push_back(m_tdata);
        $display("out data=%h last=%b spec_out=%0d", m_tdata, m_tlast, spec_out);
      end
    end
  end

  initial forever begin
    @(posedge clock);
    #1;
    if (rand_rdy) m_tready = 1'($urandom_range(0, 1));
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input int n, input int d);
    cfg_nchan = NCHAN_W'(n);
    cfg_decim = DECIM_W'(d);
    cfg_load  = 1'b1;
    tick();
    cfg_load  = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input bit l);
    int budget;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    budget   = 0;
    do begin
      tick();
      budget++;
    end while (!md_acc && budget < 200);
    if (!md_acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: beat %h not accepted within %0d cycles", d, budget);
    end
    s_tvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int bad;
    repeat (3) tick();
    chk("rst_m_tdata", m_tdata, 32'd0);
    chk("rst_m_tlast", {31'b0, m_tlast}, 32'd0);
    chk("rst_s_tready", {31'b0, s_tready}, 32'd0);
    chk("rst_spec_out", {16'b0, spec_out}, 32'd0);
    reset = 1'b0;
    tick();

    // Aligned stream, nchan=4 decim=2: spectra 0,2,4 kept.
    got.delete();
    load(4, 2);
    for (int k = 0; k < 28; k++) send(32'h1000 + k, (k % 4) == 3);
    repeat (4) tick();
    chk("t1_count", got.size(), 32'd12);
    if (got.size() == 12) begin
      chk("t1_first", got[0], 32'h1004);
      chk("t1_spec2", got[4], 32'h100C);
      chk("t1_last", got[11], 32'h1017);
    end
    chk("t1_spec_out", {16'b0, spec_out}, 32'd3);

    // Start mid-spectrum: first TLAST on beat 2.
    got.delete();
    load(4, 1);
    for (int k = 0; k < 11; k++) send(32'h2000 + k, (k % 4) == 2);
    repeat (4) tick();
    chk("t2_count", got.size(), 32'd8);
    if (got.size() > 0) chk("t2_first", got[0], 32'h2003);
    chk("t2_spec_out", {16'b0, spec_out}, 32'd5);

    // Framing errors: early TLAST (direct to RUN) then missing TLAST (realign).
    got.delete();
    fe_seen = 0;
    load(4, 1);
    send(32'h3000, 1); send(32'h3001, 0); send(32'h3002, 1);
    send(32'h3003, 0); send(32'h3004, 0); send(32'h3005, 0); send(32'h3006, 0);
    send(32'h3007, 0); send(32'h3008, 1);
    send(32'h3009, 0); send(32'h300A, 0); send(32'h300B, 0); send(32'h300C, 1);
    repeat (4) tick();
    chk("t3_fe_pulses", fe_seen, 32'd2);
    chk("t3_count", got.size(), 32'd10);
    if (got.size() == 10) chk("t3_resume", got[6], 32'h3009);
    chk("t3_spec_out", {16'b0, spec_out}, 32'd7);

    // decim=1 with random backpressure: output stream must equal input stream.
    got.delete();
    load(3, 1);
    send(32'h4000, 1);
    rand_rdy = 1'b1;
    for (int k = 0; k < 30; k++) send(32'h4100 + k, (k % 3) == 2);
    rand_rdy = 1'b0;
    m_tready = 1'b1;
    repeat (6) tick();
    chk("t4_count", got.size(), 32'd30);
    bad = 0;
    for (int i = 0; i < got.size(); i++) if (got[i] !== 32'h4100 + i) bad++;
    chk("t4_stream_bad_beats", bad, 32'd0);
    chk("t4_spec_out", {16'b0, spec_out}, 32'd17);

    // cfg_load while a beat is held; the beat offered with cfg_load is refused.
    got.delete();
    m_tready = 1'b0;
    load(4, 1);
    send(32'h5000, 1);
    send(32'h5001, 0);
    repeat (2) tick();
    cfg_nchan = NCHAN_W'(2);
    cfg_decim = DECIM_W'(1);
    cfg_load  = 1'b1;
    s_tvalid  = 1'b1; s_tdata = 32'h5002; s_tlast = 1'b1;
    tick();
    cfg_load  = 1'b0;
    s_tvalid  = 1'b0;
    repeat (3) tick();
    m_tready = 1'b1;
    repeat (2) tick();
    send(32'h5003, 1); send(32'h5004, 0); send(32'h5005, 1);
    repeat (4) tick();
    chk("t5_count", got.size(), 32'd3);
    if (got.size() == 3) begin
      chk("t5_held", got[0], 32'h5001);
      chk("t5_new_nchan", got[2], 32'h5005);
    end
    chk("t5_spec_out", {16'b0, spec_out}, 32'd18);

    // nchan=0/decim=0 behave as 1; sustained backpressure for the watchdog.
    got.delete();
    load(0, 0);
    send(32'h6000, 1);
    m_tready = 1'b0;
    send(32'h6001, 1);
    repeat (20) tick();
`ifdef PFB_DECIM_WDOG_EN
    chk("t6_stall_set", {31'b0, stall}, 32'd1);
`else
    chk("t6_stall_set", {31'b0, stall}, 32'd0);
`endif
    m_tready = 1'b1;
    tick();
    chk("t6_stall_clear", {31'b0, stall}, 32'd0);
    send(32'h6002, 1); send(32'h6003, 1); send(32'h6004, 1);
    repeat (3) tick();
    chk("t6_count", got.size(), 32'd4);
    chk("t6_spec_out", {16'b0, spec_out}, 32'd22);

    // Reset with a held beat drops it.
    m_tready = 1'b0;
    send(32'h7000, 1);
    chk("t7_held", {31'b0, m_tvalid}, 32'd1);
    reset = 1'b1;
    tick();
    chk("t7_dropped", {31'b0, m_tvalid}, 32'd0);
    reset = 1'b0;
    m_tready = 1'b1;
    tick();
    chk("t7_idle_ready", {31'b0, s_tready}, 32'd0);
    chk("t7_spec_out", {16'b0, spec_out}, 32'd0);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
